// File: rtl/seq_host.sv
// Host sequencer: streams activations and weights into SRAM, kicks the compute core, then streams results out.
// Optional watchdog on the compute wait is enabled by defining SEQ_HOST_TIMEOUT_EN.
`timescale 1ns/1ps

module seq_host #(
    parameter int ACT_WORDS      = 36,
    parameter int W_WORDS        = 72,
    parameter int OUT_WORDS      = 16,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         err,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic [31:0]  act_d,
    output logic [6:0]   act_addr,
    output logic         act_cen,
    output logic         act_wen,
    output logic [31:0]  w_d,
    output logic [6:0]   w_addr,
    output logic         w_cen,
    output logic         w_wen,
    input  logic [127:0] op_q,
    output logic [8:0]   op_addr,
    output logic         op_cen,
    output logic         op_wen,
    output logic         host_own,
    output logic         seq_begin,
    input  logic         seq_done,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_ACT,
        LOAD_W,
        KICK,
        WAIT_DONE,
        READ_REQ,
        READ_HOLD,
        FINISH
    } state_t;

    localparam logic [8:0] ACT_LAST = 9'(ACT_WORDS - 1);
    localparam logic [8:0] W_LAST   = 9'(W_WORDS - 1);
    localparam logic [8:0] OUT_LAST = 9'(OUT_WORDS - 1);

    state_t         state;
    state_t         state_next;
    logic [8:0]     cnt;
    logic           act_fire;
    logic           w_fire;
    logic           hold_first;
    logic [127:0]   data_q;
    logic           timeout;

    // SRAM write ports follow the load handshake combinationally.
    assign in_ready = (state == LOAD_ACT) || (state == LOAD_W);
    assign act_fire = (state == LOAD_ACT) && in_valid;
    assign w_fire   = (state == LOAD_W) && in_valid;

    assign act_d    = in_data;
    assign act_addr = cnt[6:0];
    assign act_cen  = !act_fire;
    assign act_wen  = !act_fire;

    assign w_d      = in_data;
    assign w_addr   = cnt[6:0];
    assign w_cen    = !w_fire;
    assign w_wen    = !w_fire;

    assign op_addr  = cnt;
    assign op_cen   = (state != READ_REQ);
    assign op_wen   = 1'b1;

    // op_q is only valid in the first READ_HOLD cycle; afterwards the captured copy keeps out_data stable.
    assign out_data = hold_first ? op_q : data_q;

`ifdef SEQ_HOST_TIMEOUT_EN
    logic [11:0] wdog;

    assign timeout = (state == WAIT_DONE) && !seq_done && (wdog == 12'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog <= '0;
            err  <= 1'b0;
        end else begin
            wdog <= (state == WAIT_DONE) ? wdog + 12'd1 : '0;
            if (timeout) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start) state_next = LOAD_ACT;
            LOAD_ACT:  if (act_fire && cnt == ACT_LAST) state_next = LOAD_W;
            LOAD_W:    if (w_fire && cnt == W_LAST) state_next = KICK;
            KICK:      state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (seq_done) begin
                    state_next = READ_REQ;
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            READ_REQ:  state_next = READ_HOLD;
            READ_HOLD: begin
                if (out_ready) begin
                    state_next = (cnt == OUT_LAST) ? FINISH : READ_REQ;
                end
            end
            FINISH:    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            seq_begin  <= 1'b0;
            host_own   <= 1'b0;
            out_valid  <= 1'b0;
            hold_first <= 1'b0;
            data_q     <= '0;
        end else begin
            state      <= state_next;
            busy       <= (state_next != IDLE);
            done       <= (state_next == FINISH);
            seq_begin  <= (state_next == KICK);
            host_own   <= state_next inside {LOAD_ACT, LOAD_W, READ_REQ, READ_HOLD, FINISH};
            out_valid  <= (state_next == READ_HOLD);
            hold_first <= (state == READ_REQ);
            if (hold_first) begin
                data_q <= op_q;
            end
            case (state)
                IDLE:      if (start) cnt <= '0;
                LOAD_ACT:  if (act_fire) cnt <= (cnt == ACT_LAST) ? '0 : cnt + 9'd1;
                LOAD_W:    if (w_fire) cnt <= (cnt == W_LAST) ? '0 : cnt + 9'd1;
                WAIT_DONE: if (seq_done) cnt <= '0;
                READ_HOLD: if (out_ready && cnt != OUT_LAST) cnt <= cnt + 9'd1;
                default:   ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_host.sv
// Scoreboard bench for seq_host: stimulus pushes expected SRAM writes, reads and results; a negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_seq_host;

    localparam int ACT_WORDS      = 36;
    localparam int W_WORDS        = 72;
    localparam int OUT_WORDS      = 16;
    localparam int TIMEOUT_CYCLES = 4095;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         busy;
    logic         done;
    logic         err;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic [31:0]  act_d;
    logic [6:0]   act_addr;
    logic         act_cen;
    logic         act_wen;
    logic [31:0]  w_d;
    logic [6:0]   w_addr;
    logic         w_cen;
    logic         w_wen;
    logic [127:0] op_q = '0;
    logic [8:0]   op_addr;
    logic         op_cen;
    logic         op_wen;
    logic         host_own;
    logic         seq_begin;
    logic         seq_done;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    seq_host #(
        .ACT_WORDS(ACT_WORDS),
        .W_WORDS(W_WORDS),
        .OUT_WORDS(OUT_WORDS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .act_d(act_d), .act_addr(act_addr), .act_cen(act_cen), .act_wen(act_wen),
        .w_d(w_d), .w_addr(w_addr), .w_cen(w_cen), .w_wen(w_wen),
        .op_q(op_q), .op_addr(op_addr), .op_cen(op_cen), .op_wen(op_wen),
        .host_own(host_own), .seq_begin(seq_begin), .seq_done(seq_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output SRAM model with one cycle read latency.
    logic [127:0] op_mem [OUT_WORDS];
    always @(posedge clk) begin
        if (!op_cen && op_wen) op_q <= op_mem[op_addr[3:0]];
    end

    int n_checks = 0;
    int n_pass   = 0;
    int done_pulses = 0;

    logic [38:0]  exp_act [$];
    logic [38:0]  exp_w   [$];
    logic [8:0]   exp_rd  [$];
    logic [127:0] exp_out [$];

    task automatic check(input string name, input logic [159:0] actual, input logic [159:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    endtask

    // Monitor: every SRAM access and result handshake must match the head of its queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (!act_cen) begin
                if (exp_act.size() == 0) check("act_extra_write", exp_act.size(), 1);
                else check("act_write", {act_wen, act_addr, act_d}, {1'b0, exp_act.pop_front()});
            end
            if (!w_cen) begin
                if (exp_w.size() == 0) check("w_extra_write", exp_w.size(), 1);
                else check("w_write", {w_wen, w_addr, w_d}, {1'b0, exp_w.pop_front()});
            end
            if (!op_cen) begin
                if (exp_rd.size() == 0) check("op_extra_read", exp_rd.size(), 1);
                else check("op_read", {op_wen, op_addr}, {1'b1, exp_rd.pop_front()});
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) check("out_extra", exp_out.size(), 1);
                else check("out_data", out_data, exp_out.pop_front());
            end
            if (done) done_pulses++;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_ctrl"}, {busy, done, err, in_ready, out_valid, host_own, seq_begin}, 7'b0);
        check({tag, "_sram"}, {act_cen, act_wen, w_cen, w_wen, op_cen, op_wen}, 6'b111111);
        check({tag, "_out_data"}, out_data, 128'b0);
    endtask

    task automatic check_drained(input string tag);
        check(tag, exp_act.size() + exp_w.size() + exp_rd.size() + exp_out.size(), 0);
    endtask

    task automatic start_job();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_load(input logic [31:0] base, input int n_w);
        for (int i = 0; i < ACT_WORDS; i++) exp_act.push_back({7'(i), base + 32'(i)});
        for (int i = 0; i < n_w; i++) exp_w.push_back({7'(i), base + 32'(ACT_WORDS + i)});
    endtask

    task automatic send_word(input logic [31:0] d, input bit gap);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("in_ready_wait", in_ready, 1'b1);
        @(posedge clk); #1;
        if (gap) begin
            in_valid = 1'b0;
            in_data  = 32'hdead_beef;
            @(posedge clk); #1;
        end
    endtask

    task automatic load_job(input logic [31:0] base, input bit gap);
        push_load(base, W_WORDS);
        start_job();
        for (int i = 0; i < ACT_WORDS + W_WORDS; i++)
            send_word(base + 32'(i), gap && (i != ACT_WORDS + W_WORDS - 1));
        in_valid = 1'b0;
    endtask

    // Entered right after the last accepted word: KICK must be the very next cycle, for one cycle only.
    task automatic kick_check();
        @(negedge clk);
        check("kick_timing", {seq_begin, host_own, busy}, 3'b101);
        @(negedge clk);
        check("kick_width", {seq_begin, host_own, busy}, 3'b001);
    endtask

    task automatic pulse_seq_done();
        seq_done = 1'b1;
        @(posedge clk); #1;
        seq_done = 1'b0;
    endtask

    task automatic read_job(input int stall_word, input int stall_cycles);
        int t [OUT_WORDS];
        int pulses_before;
        int gaps_bad = 0;
        int waited;
        pulses_before = done_pulses;
        for (int k = 0; k < OUT_WORDS; k++) begin
            exp_rd.push_back(9'(k));
            exp_out.push_back(op_mem[k]);
        end
        for (int k = 0; k < OUT_WORDS; k++) begin
            out_ready = (k != stall_word);
            waited = 0;
            @(negedge clk);
            while (!out_valid && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (!out_valid) check("out_valid_wait", out_valid, 1'b1);
            t[k] = cyc;
            if (k == stall_word) begin
                for (int s = 0; s < stall_cycles; s++) begin
                    check("stall_data", out_data, op_mem[k]);
                    check("stall_op_cen", {out_valid, op_cen}, 2'b11);
                    @(posedge clk); #1;
                    if (s != stall_cycles - 1) @(negedge clk);
                end
                out_ready = 1'b1;
                @(negedge clk);
                t[k] = cyc;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        for (int k = 1; k < OUT_WORDS; k++)
            if (k != stall_word && t[k] - t[k-1] != 2) gaps_bad++;
        check("out_spacing", gaps_bad, 0);
        @(negedge clk);
        check("done_pulse", {done, busy}, 2'b11);
        @(negedge clk);
        check("done_end", {done, busy, host_own}, 3'b000);
        check("done_count", done_pulses, pulses_before + 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        seq_done = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < OUT_WORDS; k++) op_mem[k] = 128'(k) * 128'h1111;
        #1;
        check_reset("por");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // seq_done outside WAIT_DONE must not start anything.
        pulse_seq_done();
        @(negedge clk);
        check("idle_seq_done", {busy, host_own, op_cen}, 3'b001);
        @(posedge clk); #1;

        // Job 1: continuous stream, start and in_valid poked while waiting, seq_done 50 cycles after seq_begin.
        load_job(32'd0, 1'b0);
        kick_check();
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1; in_valid = 1'b1; in_data = 32'hbad0_0000;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        repeat (38) @(posedge clk);
        #1;
        check("wait_state", {busy, host_own, seq_begin}, 3'b100);
        pulse_seq_done();
        read_job(-1, 0);
        check_drained("job1_drain");

        // Job 2: in_valid toggling, word 3 stalled for 5 cycles.
        load_job(32'd0, 1'b1);
        kick_check();
        repeat (3) @(posedge clk);
        #1;
        pulse_seq_done();
        read_job(3, 5);
        check_drained("job2_drain");

        // Job 3: reset while weight word 20 is on the bus.
        push_load(32'd0, 20);
        start_job();
        for (int i = 0; i < ACT_WORDS + 20; i++) send_word(32'(i), 1'b0);
        in_valid = 1'b1;
        in_data  = 32'(ACT_WORDS + 20);
        #1 reset = 1'b1;
        #1;
        check_reset("mid_job");
        check_drained("job3_drain");
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset = 1'b0;

        // Job 4: full job after the abort, new data pattern.
        load_job(32'h0000_1000, 1'b0);
        kick_check();
        pulse_seq_done();
        read_job(-1, 0);
        check_drained("job4_drain");

        // Job 5: seq_done never arrives.
        load_job(32'h0002_0000, 1'b0);
        kick_check();
`ifdef SEQ_HOST_TIMEOUT_EN
        begin
            int w = 1;
            int pulses_before = done_pulses;
            while (!err && w < 5000) begin
                @(negedge clk);
                w++;
            end
            check("wdog_cycles", w, TIMEOUT_CYCLES + 1);
            check("wdog_state", {err, busy, host_own, done}, 4'b1000);
            repeat (5) @(negedge clk);
            check("err_sticky", {err, busy}, 2'b10);
            check("wdog_no_done", done_pulses, pulses_before);
            @(posedge clk); #1;
            reset = 1'b1;
            #1;
            check_reset("after_wdog");
            @(posedge clk); #1;
            reset = 1'b0;
        end
`else
        repeat (300) @(negedge clk);
        check("no_wdog_wait", {busy, err, host_own, done}, 4'b1000);
        @(posedge clk); #1;
        pulse_seq_done();
        read_job(-1, 0);
`endif
        check_drained("job5_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
